// File: rtl/gstmcu_pkg.sv
// Shared types and constants for the MCU-side DMA bus sequencer.
package gstmcu_pkg;

    localparam int unsigned ADDR_W = 23;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned TO_W   = 8;

    localparam logic [1:0] REG_SEL_LO   = 2'd0;
    localparam logic [1:0] REG_SEL_MID  = 2'd1;
    localparam logic [1:0] REG_SEL_HI   = 2'd2;
    localparam logic [1:0] REG_SEL_STAT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_OWN,
        ST_MEM,
        ST_ACK,
        ST_HOLD
    } dma_state_e;

endpackage

// File: rtl/dma_bus_seq_if.sv
// DMA chip, CPU arbitration, RAM and register signals of the DMA bus sequencer.
interface dma_bus_seq_if;
    import gstmcu_pkg::*;

    logic                dma_rdy_i;
    logic                dma_rdy_o;
    logic                dma_rw;
    logic [DATA_W-1:0]   dma_din;
    logic [DATA_W-1:0]   dma_dout;
    logic                br_n;
    logic                bgack_n;
    logic                bg_n;
    logic                ram_cycle;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_dout;
    logic [DATA_W-1:0]   ram_din;
    logic                ram_ack;
    logic                reg_we;
    logic [1:0]          reg_sel;
    logic [BYTE_W-1:0]   reg_din;
    logic [BYTE_W-1:0]   reg_dout;
    logic                dma_err;

    // Sequencer side
    modport master (
        input  dma_rdy_i, dma_rw, dma_din, bg_n, ram_din, ram_ack,
               reg_we, reg_sel, reg_din,
        output dma_rdy_o, dma_dout, br_n, bgack_n, ram_cycle, ram_we,
               ram_addr, ram_dout, reg_dout, dma_err
    );

    // DMA chip / CPU / RAM side
    modport slave (
        output dma_rdy_i, dma_rw, dma_din, bg_n, ram_din, ram_ack,
               reg_we, reg_sel, reg_din,
        input  dma_rdy_o, dma_dout, br_n, bgack_n, ram_cycle, ram_we,
               ram_addr, ram_dout, reg_dout, dma_err
    );

endinterface

// File: rtl/dma_addr_cnt.sv
// 23-bit DMA word-address counter with CPU byte access and post-cycle increment.
module dma_addr_cnt
    import gstmcu_pkg::*;
(
    input  logic              clk32,
    input  logic              rst,
    input  logic              i_we,
    input  logic [1:0]        i_sel,
    input  logic [BYTE_W-1:0] i_din,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_addr,
    output logic [BYTE_W-1:0] o_rdata_c
);

    logic [ADDR_W-1:0] r_cnt;

    // CPU write has priority over the increment of a finished word
    always_ff @(posedge clk32) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_we && (i_sel != REG_SEL_STAT)) begin
            case (i_sel)
                REG_SEL_LO:  r_cnt[6:0]   <= i_din[7:1];
                REG_SEL_MID: r_cnt[14:7]  <= i_din;
                default:     r_cnt[22:15] <= i_din;
            endcase
        end else if (i_inc) begin
            r_cnt <= r_cnt + ADDR_W'(1);
        end
    end

    // Byte view of the counter as a byte address (bit 0 always reads 0)
    always_comb begin
        o_rdata_c = '0;
        case (i_sel)
            REG_SEL_LO:  o_rdata_c = {r_cnt[6:0], 1'b0};
            REG_SEL_MID: o_rdata_c = r_cnt[14:7];
            REG_SEL_HI:  o_rdata_c = r_cnt[22:15];
            default:     o_rdata_c = '0;
        endcase
    end

    assign o_addr = r_cnt;

endmodule

// File: rtl/dma_bus_seq.sv
// MCU-side DMA bus sequencer: request detect, bus arbitration, one RAM word per ack.
// Optional DMA_GRANT_TIMEOUT_EN: abort a bus request after 255 ungranted clk_en ticks.
module dma_bus_seq
    import gstmcu_pkg::*;
#(
    parameter int unsigned HOLD = 4
) (
    input  logic          clk32,
    input  logic          rst,
    input  logic          clk_en,
    dma_bus_seq_if.master bus
);

    localparam int unsigned HOLD_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

    dma_state_e          r_state;
    logic                r_rdy_d;
    logic                r_pend;
    logic                r_br_n;
    logic                r_bgack_n;
    logic                r_ram_cycle;
    logic                r_ram_we;
    logic                r_rdy_o;
    logic [DATA_W-1:0]   r_dout;
    logic [DATA_W-1:0]   r_ram_dout;
    logic [HOLD_W-1:0]   r_hold;

    logic                w_req;
    logic                w_start;
    logic                w_inc;
    logic                w_timeout;
    logic                w_err;
    logic [ADDR_W-1:0]   w_addr;
    logic [BYTE_W-1:0]   w_cnt_rdata;

    assign w_req   = bus.dma_rdy_i & ~r_rdy_d;
    assign w_start = clk_en & ((r_state == ST_OWN) | ((r_state == ST_HOLD) & r_pend));
    assign w_inc   = (r_state == ST_MEM) & bus.ram_ack;

    // Edge detector keeps tracking the level through reset so a held line is not a new request
    always_ff @(posedge clk32) begin
        r_rdy_d <= bus.dma_rdy_i;
    end

`ifdef DMA_GRANT_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;
    logic            w_stat_wr;

    assign w_stat_wr = bus.reg_we & (bus.reg_sel == REG_SEL_STAT);
    // The 255th ungranted tick in REQ aborts the request
    assign w_timeout = (r_state == ST_REQ) & clk_en & bus.bg_n & (r_to_cnt == TO_W'(254));

    always_ff @(posedge clk32) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state != ST_REQ) begin
                r_to_cnt <= '0;
            end else if (clk_en && bus.bg_n) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (w_stat_wr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign w_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign w_err     = 1'b0;
`endif

    // Sequencer FSM with registered bus and handshake outputs
    always_ff @(posedge clk32) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pend      <= 1'b0;
            r_br_n      <= 1'b1;
            r_bgack_n   <= 1'b1;
            r_ram_cycle <= 1'b0;
            r_ram_we    <= 1'b0;
            r_rdy_o     <= 1'b0;
            r_dout      <= '0;
            r_ram_dout  <= '0;
            r_hold      <= '0;
        end else begin
            r_rdy_o <= 1'b0;
            if (w_req) begin
                r_pend <= 1'b1;
            end else if (w_start || w_timeout) begin
                r_pend <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (clk_en && r_pend) begin
                        r_state <= ST_REQ;
                        r_br_n  <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (clk_en && !bus.bg_n) begin
                        r_state   <= ST_OWN;
                        r_bgack_n <= 1'b0;
                        r_br_n    <= 1'b1;
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                        r_br_n  <= 1'b1;
                    end
                end
                ST_OWN: begin
                    if (clk_en) begin
                        r_state     <= ST_MEM;
                        r_ram_cycle <= 1'b1;
                        r_ram_we    <= ~bus.dma_rw;
                        r_ram_dout  <= bus.dma_din;
                    end
                end
                ST_MEM: begin
                    if (bus.ram_ack) begin
                        r_state     <= ST_ACK;
                        r_ram_cycle <= 1'b0;
                        r_ram_we    <= 1'b0;
                        r_rdy_o     <= 1'b1;
                        if (bus.dma_rw) begin
                            r_dout <= bus.ram_din;
                        end
                    end
                end
                ST_ACK: begin
                    r_state <= ST_HOLD;
                    r_hold  <= HOLD_W'(HOLD);
                end
                ST_HOLD: begin
                    // Keep the bus for a follow-on word; skip re-arbitration
                    if (clk_en) begin
                        if (r_pend) begin
                            r_state     <= ST_MEM;
                            r_ram_cycle <= 1'b1;
                            r_ram_we    <= ~bus.dma_rw;
                            r_ram_dout  <= bus.dma_din;
                        end else if (r_hold == '0) begin
                            r_state   <= ST_IDLE;
                            r_bgack_n <= 1'b1;
                        end else begin
                            r_hold <= r_hold - HOLD_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    dma_addr_cnt u_addr_cnt (
        .clk32     (clk32),
        .rst       (rst),
        .i_we      (bus.reg_we),
        .i_sel     (bus.reg_sel),
        .i_din     (bus.reg_din),
        .i_inc     (w_inc),
        .o_addr    (w_addr),
        .o_rdata_c (w_cnt_rdata)
    );

    always_comb begin
        bus.reg_dout = w_cnt_rdata;
        if (bus.reg_sel == REG_SEL_STAT) begin
            bus.reg_dout = {6'b0, w_err, (r_state != ST_IDLE)};
        end
    end

    assign bus.dma_rdy_o = r_rdy_o;
    assign bus.dma_dout  = r_dout;
    assign bus.br_n      = r_br_n;
    assign bus.bgack_n   = r_bgack_n;
    assign bus.ram_cycle = r_ram_cycle;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = w_addr;
    assign bus.ram_dout  = r_ram_dout;
    assign bus.dma_err   = w_err;

endmodule

// File: tb/tb_dma_bus_seq.sv
// Directed/randomized bench for dma_bus_seq with a RAM/CPU responder and word-level reference model.
module tb_dma_bus_seq;
    import gstmcu_pkg::*;

    localparam int unsigned HOLD_T = 4;
    localparam int unsigned WMOD   = 32'h0080_0000;

    logic clk32 = 1'b0;
    logic rst;
    logic clk_en;

    dma_bus_seq_if bus ();

    dma_bus_seq #(.HOLD(HOLD_T)) dut (
        .clk32  (clk32),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clk32 = ~clk32;

    // Environment controls (written by the stimulus block only)
    logic        cpu_stall   = 1'b0;
    logic        ram_auto    = 1'b1;
    logic        ack_force   = 1'b0;
    logic [15:0] preload_val = 16'h0000;

    // Responder: clock enable, CPU grant, RAM with random latency
    int unsigned       ph  = 0;
    int unsigned       dly = 0;
    logic [15:0]       ram [int unsigned];
    always @(negedge clk32) begin : env
        logic        hit;
        int unsigned a;
        ph     = (ph + 1) % 4;
        clk_en = (ph == 0);
        bus.bg_n = cpu_stall | bus.br_n;
        hit = 1'b0;
        if (bus.ram_ack !== 1'b1 && bus.ram_cycle === 1'b1 && ram_auto) begin
            if (dly == 0) begin
                hit = 1'b1;
                a   = 32'(bus.ram_addr);
                if (bus.ram_we) ram[a] = bus.ram_dout;
                bus.ram_din = ram.exists(a) ? ram[a] : preload_val;
                dly = $urandom_range(0, 3);
            end else begin
                dly = dly - 1;
            end
        end
        bus.ram_ack = hit | ack_force;
    end

    // Monitor, sampled between edges
    int unsigned n_ack = 0, n_long = 0, n_late = 0, n_glitch = 0, n_br_fall = 0;
    logic [22:0] cap_addr;
    logic        cap_we;
    logic [15:0] cap_wdat, cap_rd;
    logic        p_rdy_o = 1'b0, p_ack = 1'b0, p_cyc = 1'b0, p_br = 1'b1;
    logic [22:0] p_addr = '0;
    always @(negedge clk32) begin : mon
        #2;
        if (bus.dma_rdy_o === 1'b1) begin
            n_ack++;
            cap_rd = bus.dma_dout;
            if (p_rdy_o) n_long++;
            if (!p_ack) n_late++;
        end
        if (bus.ram_cycle === 1'b1 && bus.ram_ack === 1'b1) begin
            cap_addr = bus.ram_addr;
            cap_we   = bus.ram_we;
            cap_wdat = bus.ram_dout;
        end
        if (bus.ram_cycle === 1'b1 && p_cyc && bus.ram_addr !== p_addr) n_glitch++;
        if (bus.br_n === 1'b0 && p_br) n_br_fall++;
        p_rdy_o = (bus.dma_rdy_o === 1'b1);
        p_ack   = (bus.ram_ack === 1'b1);
        p_cyc   = (bus.ram_cycle === 1'b1);
        p_addr  = bus.ram_addr;
        p_br    = (bus.br_n !== 1'b0);
    end

    // Reference model state
    int unsigned n_chk = 0, n_pass = 0, n_fail = 0;
    int unsigned exp_cnt = 0;
    logic [15:0] exp_mem [int unsigned];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reg_wr(input logic [1:0] sel, input logic [7:0] d);
        @(negedge clk32);
        bus.reg_we = 1'b1; bus.reg_sel = sel; bus.reg_din = d;
        @(negedge clk32);
        bus.reg_we = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] sel, output logic [7:0] d);
        @(negedge clk32);
        bus.reg_sel = sel;
        #1 d = bus.reg_dout;
    endtask

    task automatic set_cnt(input int unsigned w);
        logic [22:0] v;
        v = 23'(w);
        reg_wr(REG_SEL_HI,  v[22:15]);
        reg_wr(REG_SEL_MID, v[14:7]);
        reg_wr(REG_SEL_LO,  {v[6:0], 1'b0});
        exp_cnt = w % WMOD;
    endtask

    // Byte address read back through the three counter registers
    task automatic get_byte_addr(output logic [23:0] ba);
        logic [7:0] h, m, l;
        reg_rd(REG_SEL_HI, h);
        reg_rd(REG_SEL_MID, m);
        reg_rd(REG_SEL_LO, l);
        ba = {h, m, l};
    endtask

    task automatic rdy_raise(input logic rw, input logic [15:0] din);
        @(negedge clk32);
        bus.dma_rw = rw; bus.dma_din = din; bus.dma_rdy_i = 1'b1;
    endtask

    task automatic wait_ack(input int unsigned a0, input int unsigned budget, output logic ok);
        for (int i = 0; i < int'(budget); i++) begin
            @(negedge clk32);
            if (n_ack != a0) break;
        end
        ok = (n_ack != a0);
    endtask

    // One word through the handshake, checked against the reference model
    task automatic word(input logic rw, input logic [15:0] din, input string tag);
        int unsigned a0;
        logic        ok;
        logic [15:0] exp_rd;
        a0 = n_ack;
        exp_rd = exp_mem.exists(exp_cnt) ? exp_mem[exp_cnt] : preload_val;
        rdy_raise(rw, din);
        wait_ack(a0, 200, ok);
        bus.dma_rdy_i = 1'b0;
        chk({tag, "_ack"}, 32'(ok), 32'd1);
        chk({tag, "_addr"}, 32'(cap_addr), exp_cnt);
        chk({tag, "_we"}, 32'(cap_we), rw ? 32'd0 : 32'd1);
        if (rw) begin
            chk({tag, "_rdata"}, 32'(cap_rd), 32'(exp_rd));
        end else begin
            chk({tag, "_wdata"}, 32'(cap_wdat), 32'(din));
            exp_mem[exp_cnt] = din;
        end
        exp_cnt = (exp_cnt + 1) % WMOD;
    endtask

    initial begin : stim
        logic [7:0]  b;
        logic [23:0] ba;
        int unsigned a0, f0;
        logic        ok, rw;
        logic [15:0] d;

        rst = 1'b1;
        bus.dma_rdy_i = 1'b0; bus.dma_rw = 1'b0; bus.dma_din = '0;
        bus.reg_we = 1'b0; bus.reg_sel = REG_SEL_LO; bus.reg_din = '0;
        repeat (4) @(negedge clk32);
        #2;
        chk("rst_br_n", 32'(bus.br_n), 32'd1);
        chk("rst_bgack_n", 32'(bus.bgack_n), 32'd1);
        chk("rst_ram_cycle", 32'(bus.ram_cycle), 32'd0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
        chk("rst_rdy_o", 32'(bus.dma_rdy_o), 32'd0);
        chk("rst_dout", 32'(bus.dma_dout), 32'd0);
        chk("rst_err", 32'(bus.dma_err), 32'd0);
        rst = 1'b0;
        get_byte_addr(ba);
        chk("rst_cnt", 32'(ba), 32'd0);
        reg_rd(REG_SEL_STAT, b);
        chk("rst_status", 32'(b), 32'd0);

        // Bit 0 of the low byte is not stored
        reg_wr(REG_SEL_LO, 8'hFF);
        reg_rd(REG_SEL_LO, b);
        chk("lo_bit0", 32'(b), 32'hFE);

        // Sixteen memory writes from byte address 0x000100
        reg_wr(REG_SEL_HI, 8'h00);
        reg_wr(REG_SEL_MID, 8'h01);
        reg_wr(REG_SEL_LO, 8'h00);
        exp_cnt = 32'h80;
        a0 = n_ack;
        for (int i = 0; i < 16; i++) word(1'b0, 16'(32'h200 + i), "wr16");
        chk("wr16_pulses", n_ack - a0, 32'd16);
        get_byte_addr(ba);
        chk("wr16_cnt", 32'(ba), 32'h000120);

        // Memory read of preloaded RAM
        set_cnt(32'h1000);
        preload_val = 16'hA5A5;
        word(1'b1, 16'h0000, "rdA5");
        set_cnt(32'h84);
        word(1'b1, 16'h0000, "rdback");

        // Counter wrap at the top of the word space
        set_cnt(32'h7F_FFFF);
        word(1'b0, 16'hBEEF, "wrap");
        get_byte_addr(ba);
        chk("wrap_cnt", 32'(ba), 32'd0);

        // Random traffic
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 0) set_cnt($urandom_range(0, 32'h7F_FFFF));
            rw = 1'($urandom_range(0, 1));
            d  = 16'($urandom);
            preload_val = 16'($urandom);
            word(rw, d, "rnd");
        end

        // Back-to-back words stay on one arbitration; a long gap releases the bus
        repeat (60) @(negedge clk32);
        #2;
        chk("gap_bgack_rel", 32'(bus.bgack_n), 32'd1);
        f0 = n_br_fall;
        for (int i = 0; i < 4; i++) word(1'b0, 16'(32'h3000 + i), "hold");
        chk("hold_one_br", n_br_fall - f0, 32'd1);
        repeat (60) @(negedge clk32);
        #2;
        chk("gap2_bgack_rel", 32'(bus.bgack_n), 32'd1);
        reg_rd(REG_SEL_STAT, b);
        chk("gap2_status", 32'(b), 32'd0);
        f0 = n_br_fall;
        word(1'b0, 16'h4444, "rearb");
        chk("rearb_br", n_br_fall - f0, 32'd1);
        repeat (60) @(negedge clk32);

        // Ungranted bus request
        cpu_stall = 1'b1;
        a0 = n_ack;
`ifdef DMA_GRANT_TIMEOUT_EN
        rdy_raise(1'b0, 16'h5555);
        repeat (800) @(negedge clk32);
        #2;
        chk("to_early_err", 32'(bus.dma_err), 32'd0);
        chk("to_early_br", 32'(bus.br_n), 32'd0);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk32);
            if (bus.dma_err === 1'b1) break;
        end
        #2;
        chk("to_err", 32'(bus.dma_err), 32'd1);
        chk("to_br_rel", 32'(bus.br_n), 32'd1);
        bus.dma_rdy_i = 1'b0;
        reg_rd(REG_SEL_STAT, b);
        chk("to_status", 32'(b), 32'h02);
        reg_wr(REG_SEL_STAT, 8'h00);
        #2;
        chk("to_clear", 32'(bus.dma_err), 32'd0);
        cpu_stall = 1'b0;
        repeat (40) @(negedge clk32);
        chk("to_no_ack", n_ack - a0, 32'd0);
`else
        rdy_raise(1'b0, 16'h5555);
        repeat (1200) @(negedge clk32);
        #2;
        chk("nto_err", 32'(bus.dma_err), 32'd0);
        chk("nto_br", 32'(bus.br_n), 32'd0);
        chk("nto_no_ack", n_ack - a0, 32'd0);
        reg_rd(REG_SEL_STAT, b);
        chk("nto_status", 32'(b), 32'h01);
        cpu_stall = 1'b0;
        wait_ack(a0, 200, ok);
        bus.dma_rdy_i = 1'b0;
        chk("nto_ack", 32'(ok), 32'd1);
        chk("nto_addr", 32'(cap_addr), exp_cnt);
        chk("nto_wdata", 32'(cap_wdat), 32'h5555);
        exp_cnt = (exp_cnt + 1) % WMOD;
`endif
        repeat (60) @(negedge clk32);

        // Reset in the middle of a RAM cycle
        ram_auto = 1'b0;
        a0 = n_ack;
        rdy_raise(1'b0, 16'h6666);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk32);
            if (bus.ram_cycle === 1'b1) break;
        end
        chk("mid_cycle", 32'(bus.ram_cycle), 32'd1);
        rst = 1'b1;
        bus.dma_rdy_i = 1'b0;
        @(negedge clk32);
        #2;
        chk("mrst_ram_cycle", 32'(bus.ram_cycle), 32'd0);
        chk("mrst_bgack_n", 32'(bus.bgack_n), 32'd1);
        chk("mrst_br_n", 32'(bus.br_n), 32'd1);
        chk("mrst_ram_we", 32'(bus.ram_we), 32'd0);
        chk("mrst_dout", 32'(bus.dma_dout), 32'd0);
        chk("mrst_rdy_o", 32'(bus.dma_rdy_o), 32'd0);
        get_byte_addr(ba);
        chk("mrst_cnt", 32'(ba), 32'd0);
        rst = 1'b0;
        @(negedge clk32);
        ack_force = 1'b1;
        @(negedge clk32);
        ack_force = 1'b0;
        repeat (20) @(negedge clk32);
        #2;
        chk("mrst_late_ack", n_ack - a0, 32'd0);
        chk("mrst_idle_cycle", 32'(bus.ram_cycle), 32'd0);
        reg_rd(REG_SEL_STAT, b);
        chk("mrst_status", 32'(b), 32'd0);
        ram_auto = 1'b1;

        // Whole-run handshake properties
        chk("rdy_o_one_cycle", n_long, 32'd0);
        chk("rdy_o_after_ack", n_late, 32'd0);
        chk("addr_stable", n_glitch, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
